// File: rtl/lab71_2_pio_pkg.sv
// ---------------------------------------------------------------------------
// lab71_2_pio_pkg
//
// Shared definitions for the lab71_2 PIO slaves on the s1 Avalon-MM bus.
// The register map is common to the input and output PIOs, so the word
// addresses live here rather than in each slave.
//
// Contents:
//   pio_addr_e       word addresses of the four PIO registers
//   PIO_EDGE_*       encodings for the EDGE_TYPE parameter of the input PIO
//   PIO_BUS_W        Avalon data bus width
// ---------------------------------------------------------------------------
package lab71_2_pio_pkg;

    // Word addresses of the PIO registers. DIR is only meaningful on a
    // bidirectional PIO; the input-only PIO treats it as reserved.
    typedef enum logic [1:0] {
        PIO_ADDR_DATA    = 2'd0,
        PIO_ADDR_DIR     = 2'd1,
        PIO_ADDR_IRQMASK = 2'd2,
        PIO_ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    // Which input transition sets an EDGECAP bit.
    localparam int PIO_EDGE_RISE = 0;
    localparam int PIO_EDGE_FALL = 1;
    localparam int PIO_EDGE_ANY  = 2;

    // Avalon-MM data width of the s1 bus.
    localparam int PIO_BUS_W = 32;

endpackage

// File: rtl/lab71_2_keys_pio_if.sv
// ---------------------------------------------------------------------------
// lab71_2_keys_pio_if
//
// Avalon-MM s1 slave port of the keys PIO, plus its interrupt line.
//
// Signals:
//   address     word address of the register being accessed
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    combinational read data (zero-wait, latency 0)
//   irq         active-high level interrupt toward the processor
//
// Modports:
//   master  the interconnect / processor side
//   slave   the PIO side
// ---------------------------------------------------------------------------
interface lab71_2_keys_pio_if;
    import lab71_2_pio_pkg::*;

    logic [1:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [PIO_BUS_W-1:0] writedata;
    logic [PIO_BUS_W-1:0] readdata;
    logic                 irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );

endinterface

// File: rtl/lab71_2_pio_debounce.sv
// ---------------------------------------------------------------------------
// lab71_2_pio_debounce
//
// Single-bit debouncer for the keys PIO. Used only when
// LAB71_2_KEYS_PIO_DEBOUNCE_EN is defined.
//
// The stable output follows the synchronized input only after the input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clock cycles. Any cycle
// in which they agree again restarts the count from zero.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept a change
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   s2_in     synchronized input bit (output of the 2-flop synchronizer)
//   stab_out  debounced stable bit
// ---------------------------------------------------------------------------
module lab71_2_pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s2_in,
    output logic stab_out
);

    // A zero-cycle debounce would give a zero-width counter; keep one bit.
    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stab_q;
    logic             stab_d;

    // Count cycles of disagreement. The cycle that completes the required
    // run flips the stable bit and rearms the counter. The counter holds at
    // its maximum rather than wrapping back to a small value.
    always_comb begin
        stab_d = stab_q;
        cnt_d  = '0;
        if (s2_in != stab_q) begin
            if (int'(cnt_q) + 1 >= DEBOUNCE_CYCLES) begin
                stab_d = s2_in;
                cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            stab_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stab_q <= stab_d;
        end
    end

    assign stab_out = stab_q;

endmodule

// File: rtl/lab71_2_keys_pio.sv
// ---------------------------------------------------------------------------
// lab71_2_keys_pio
//
// Avalon-MM input PIO for push-buttons / switches. Synchronizes in_port into
// the clk domain, exposes the live level on DATA, latches selected edges in
// a write-1-to-clear EDGECAP register and drives a maskable level irq.
//
// Register map (word addresses):
//   0 DATA     read-only stable input value
//   1 -        reserved, reads 0
//   2 IRQMASK  read/write interrupt enable per bit
//   3 EDGECAP  read, write 1 to clear a bit
//
// Build option:
//   LAB71_2_KEYS_PIO_DEBOUNCE_EN  when defined, each input bit passes through
//                                 a lab71_2_pio_debounce instance; otherwise
//                                 the synchronizer output is used directly.
//
// Parameters:
//   WIDTH            number of input bits (1..32)
//   EDGE_TYPE        PIO_EDGE_RISE / PIO_EDGE_FALL / PIO_EDGE_ANY
//   DEBOUNCE_CYCLES  debounce length in cycles (debounce builds only)
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_port  asynchronous external inputs
//   bus      Avalon-MM s1 slave port and irq (lab71_2_keys_pio_if.slave)
// ---------------------------------------------------------------------------
module lab71_2_keys_pio
    import lab71_2_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    lab71_2_keys_pio_if.slave bus
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stab;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [1:0]       warm_q, warm_d;

    logic             wr_en;
    logic             capture_en;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c_bits;
    logic             unused_wdata_bits;

    // Only the low WIDTH bits of writedata are meaningful; the rest are
    // folded away here so they are visibly consumed.
    assign unused_wdata_bits = ^bus.writedata;

    assign wr_en = bus.chipselect && !bus.write_n;

    // Synchronizer, previous-value register and warm-up counter. The counter
    // saturates at 3; by then prev has been loaded from a genuinely sampled
    // stab, so reset values can no longer look like an edge.
    always_comb begin
        s1_d   = in_port;
        s2_d   = s1_q;
        prev_d = stab;
        warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    assign capture_en = (warm_q == 2'd3);

    // Stable value: either the debounced synchronizer output or the
    // synchronizer output itself.
`ifdef LAB71_2_KEYS_PIO_DEBOUNCE_EN
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        lab71_2_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .s2_in    (s2_q[gi]),
            .stab_out (stab[gi])
        );
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign stab = s2_q;
`endif

    // Per-bit edge detection on the stable value, gated by warm-up.
    always_comb begin
        rise     = stab & ~prev_q;
        fall     = ~stab & prev_q;
        edge_hit = '0;
        if (capture_en) begin
            if (EDGE_TYPE == PIO_EDGE_RISE) begin
                edge_hit = rise;
            end else if (EDGE_TYPE == PIO_EDGE_FALL) begin
                edge_hit = fall;
            end else begin
                edge_hit = rise | fall;
            end
        end
    end

    // Register writes. The W1C clear is applied first and the new edges are
    // OR-ed in afterwards, so an edge arriving in the same cycle as a clear
    // of that bit wins and the bit stays set.
    always_comb begin
        irqmask_d = irqmask_q;
        w1c_bits  = '0;
        if (wr_en && (bus.address == PIO_ADDR_IRQMASK)) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == PIO_ADDR_EDGECAP)) begin
            w1c_bits = bus.writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~w1c_bits) | edge_hit;
    end

    // All state shares one asynchronous active-low reset, so a mid-operation
    // reset drops pending edges and restarts warm-up at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            warm_q    <= 2'd0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            prev_q    <= prev_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            warm_q    <= warm_d;
        end
    end

    // Zero-wait read mux, independent of chipselect, zero-extended to the
    // bus width. Reads have no side effects.
    always_comb begin
        bus.readdata = '0;
        case (pio_addr_e'(bus.address))
            PIO_ADDR_DATA:    bus.readdata[WIDTH-1:0] = stab;
            PIO_ADDR_DIR:     bus.readdata = '0;
            PIO_ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecap_q;
            default:          bus.readdata = '0;
        endcase
    end

    // Level interrupt straight from registers, so it follows IRQMASK and
    // EDGECAP one cycle after they are written.
    assign bus.irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_lab71_2_keys_pio.sv
// ---------------------------------------------------------------------------
// tb_lab71_2_keys_pio
//
// Directed self-checking bench for lab71_2_keys_pio (WIDTH=4, falling-edge
// capture). Inputs are driven and outputs sampled around the falling clock
// edge. When LAB71_2_KEYS_PIO_DEBOUNCE_EN is defined the DUT is built with
// DEBOUNCE_CYCLES=8 and all expected latencies grow by that amount.
// ---------------------------------------------------------------------------
module tb_lab71_2_keys_pio;
    import lab71_2_pio_pkg::*;

`ifdef LAB71_2_KEYS_PIO_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;
    int         checkCount = 0;
    int         failCount  = 0;

    lab71_2_keys_pio_if bus ();

    lab71_2_keys_pio #(
        .WIDTH           (4),
        .EDGE_TYPE       (PIO_EDGE_FALL),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the key inputs and let n rising edges go by.
    task automatic applyStimulus(input logic [3:0] value, input int n);
        in_port = value;
        waitEdges(n);
    endtask

    // Combinational read: present the address, let it settle, sample.
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [1:0] addr,
                            input logic [31:0] expected);
        logic [31:0] data;
        readReg(addr, data);
        checkOutput(tag, data, expected);
    endtask

    // One-cycle write; returns at the falling edge after the write edge.
    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    // Safety net so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL timeout reached");
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        in_port        = 4'hF;
        reset_n        = 1'b0;

        // Reset state with keys held high.
        waitEdges(3);
        checkReg("rst_data", PIO_ADDR_DATA, 32'h0);
        checkReg("rst_edgecap", PIO_ADDR_EDGECAP, 32'h0);
        checkReg("rst_irqmask", PIO_ADDR_IRQMASK, 32'h0);
        checkOutput("rst_irq", 32'(bus.irq), 32'h0);

        // Release: DATA shows the keys after the synchronizer (+debounce).
        @(negedge clk);
        reset_n = 1'b1;
        waitEdges(1 + DB);
        checkReg("sync_lat_data", PIO_ADDR_DATA, 32'h0);
        waitEdges(1);
        checkReg("post_rst_data", PIO_ADDR_DATA, 32'hF);
        waitEdges(4);
        checkReg("post_rst_edgecap", PIO_ADDR_EDGECAP, 32'h0);
        checkOutput("post_rst_irq", 32'(bus.irq), 32'h0);

        // Falling edge on bit 0 with bit 0 unmasked.
        writeReg(PIO_ADDR_IRQMASK, 32'h1);
        checkReg("mask_rd", PIO_ADDR_IRQMASK, 32'h1);
        applyStimulus(4'hE, 2 + DB);
        checkReg("fall_data", PIO_ADDR_DATA, 32'hE);
        checkReg("fall_cap_early", PIO_ADDR_EDGECAP, 32'h0);
        checkOutput("fall_irq_early", 32'(bus.irq), 32'h0);
        waitEdges(1);
        checkReg("fall_cap", PIO_ADDR_EDGECAP, 32'h1);
        checkOutput("fall_irq", 32'(bus.irq), 32'h1);
        writeReg(PIO_ADDR_EDGECAP, 32'h1);
        checkReg("w1c_cap", PIO_ADDR_EDGECAP, 32'h0);
        checkOutput("w1c_irq", 32'(bus.irq), 32'h0);

        // Rising edges are not captured in falling-edge mode.
        applyStimulus(4'hF, 5 + DB);
        checkReg("rise_data", PIO_ADDR_DATA, 32'hF);
        checkReg("rise_nocap", PIO_ADDR_EDGECAP, 32'h0);

        // Masking: capture bits 1 and 2 with no interrupt enabled.
        writeReg(PIO_ADDR_IRQMASK, 32'h0);
        applyStimulus(4'h9, 3 + DB);
        checkReg("mask_cap", PIO_ADDR_EDGECAP, 32'h6);
        checkOutput("mask_irq_off", 32'(bus.irq), 32'h0);
        writeReg(PIO_ADDR_IRQMASK, 32'h4);
        checkOutput("mask_irq_on", 32'(bus.irq), 32'h1);
        writeReg(PIO_ADDR_EDGECAP, 32'h2);
        checkReg("w1c_partial", PIO_ADDR_EDGECAP, 32'h4);
        checkOutput("w1c_partial_irq", 32'(bus.irq), 32'h1);
        writeReg(PIO_ADDR_EDGECAP, 32'h4);
        checkReg("w1c_rest", PIO_ADDR_EDGECAP, 32'h0);
        checkOutput("w1c_rest_irq", 32'(bus.irq), 32'h0);

        // Edge on bit 3 lands in the same cycle as a W1C of bit 3.
        applyStimulus(4'h1, 2 + DB);
        writeReg(PIO_ADDR_EDGECAP, 32'h8);
        checkReg("simul_cap", PIO_ADDR_EDGECAP, 32'h8);
        writeReg(PIO_ADDR_EDGECAP, 32'h8);
        checkReg("simul_clear", PIO_ADDR_EDGECAP, 32'h0);

        // Read-only and reserved registers, upper write bits dropped.
        writeReg(PIO_ADDR_DATA, 32'h0);
        checkReg("data_ro", PIO_ADDR_DATA, 32'h1);
        writeReg(PIO_ADDR_DIR, 32'hFFFF_FFFF);
        checkReg("dir_zero", PIO_ADDR_DIR, 32'h0);
        writeReg(PIO_ADDR_IRQMASK, 32'hFFFF_FFFA);
        checkReg("mask_width", PIO_ADDR_IRQMASK, 32'hA);

`ifdef LAB71_2_KEYS_PIO_DEBOUNCE_EN
        // A 5-cycle glitch on bit 0 is filtered out entirely.
        applyStimulus(4'h0, 5);
        applyStimulus(4'h1, 12);
        checkReg("glitch_data", PIO_ADDR_DATA, 32'h1);
        checkReg("glitch_nocap", PIO_ADDR_EDGECAP, 32'h0);
`endif

        // Mid-operation reset with all bits captured and unmasked.
        applyStimulus(4'hF, 4 + DB);
        applyStimulus(4'h0, 3 + DB);
        checkReg("all_cap", PIO_ADDR_EDGECAP, 32'hF);
        applyStimulus(4'hF, 3 + DB);
        writeReg(PIO_ADDR_IRQMASK, 32'hF);
        checkReg("pre_rst_data", PIO_ADDR_DATA, 32'hF);
        checkOutput("pre_rst_irq", 32'(bus.irq), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_irq", 32'(bus.irq), 32'h0);
        checkReg("mid_rst_data", PIO_ADDR_DATA, 32'h0);
        checkReg("mid_rst_edgecap", PIO_ADDR_EDGECAP, 32'h0);
        checkReg("mid_rst_irqmask", PIO_ADDR_IRQMASK, 32'h0);

        // Capture works again once warm-up has elapsed.
        @(negedge clk);
        reset_n = 1'b1;
        waitEdges(6 + DB);
        checkReg("rewarm_nocap", PIO_ADDR_EDGECAP, 32'h0);
        applyStimulus(4'h7, 3 + DB);
        checkReg("rewarm_cap", PIO_ADDR_EDGECAP, 32'h8);
        checkOutput("rewarm_irq", 32'(bus.irq), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
